alu_vectorial: RTL and testbench

- Lane-parallel (SIMD) ALU: n_alu identical WIDTH-bit ALU lanes run the same operation on packed operand vectors a and b.
- Produces a packed result, per-lane carry/borrow and per-lane unsigned magnitude-compare flags.
- All outputs are registered on clk.
- Sits in the datapath as a vector execution unit.
- Interface bundle alu_if carries all ports for verification.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_if.sv | 30 +++
 rtl/alu_lane.sv | 59 +++++
 rtl/alu_vectorial.sv | 65 ++++++
 tb/tb_alu_vectorial.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and default sizing for the SIMD ALU.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } alu_op_e;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_N_ALU = 4;

endpackage

// File: rtl/alu_if.sv
// Signal bundle for the SIMD ALU: operand/opcode inputs and registered result/flag outputs.
interface alu_if #(
   parameter int WIDTH = 4,
   parameter int n_alu = 4
) (
   input logic clk
);

   logic                     rst;
   logic [n_alu*WIDTH-1:0]   a;
   logic [n_alu*WIDTH-1:0]   b;
   logic [2:0]               select;
   logic [n_alu*WIDTH-1:0]   data_out;
   logic [n_alu-1:0]         carry_out;
   logic [n_alu-1:0]         a_greater;
   logic [n_alu-1:0]         a_equal;
   logic [n_alu-1:0]         a_less;

   modport master (
      input  clk,
      output rst, a, b, select,
      input  data_out, carry_out, a_greater, a_equal, a_less
   );

   modport slave (
      input  a, b, select,
      output data_out, carry_out, a_greater, a_equal, a_less
   );

endinterface

// File: rtl/alu_lane.sv
// One combinational ALU lane: result, carry/borrow and unsigned compare flags.
module alu_lane
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_e          op,
   output logic [WIDTH-1:0] res,
   output logic             carry,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_diff;

   // The extra MSB of the widened difference is the borrow.
   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      res   = '0;
      carry = 1'b0;
      case (op)
         OP_ADD: begin
            res   = w_sum[WIDTH-1:0];
            carry = w_sum[WIDTH];
         end
         OP_SUB: begin
            res   = w_diff[WIDTH-1:0];
            carry = w_diff[WIDTH];
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_NOT: res = ~a;
         OP_SHL: begin
            res   = {a[WIDTH-2:0], 1'b0};
            carry = a[WIDTH-1];
         end
         OP_SHR: begin
            res   = {1'b0, a[WIDTH-1:1]};
            carry = a[0];
         end
         default: begin
            res   = '0;
            carry = 1'b0;
         end
      endcase
   end

   assign gt = (a > b);
   assign eq = (a == b);
   assign lt = (a < b);

endmodule

// File: rtl/alu_vectorial.sv
// Lane-parallel ALU: n_alu independent lanes share one opcode; all outputs registered.
module alu_vectorial
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int n_alu = DEF_N_ALU
) (
   input logic  clk,
   input logic  rst,
   alu_if.slave bus
);

   logic [n_alu*WIDTH-1:0] w_res;
   logic [n_alu-1:0]       w_carry;
   logic [n_alu-1:0]       w_gt;
   logic [n_alu-1:0]       w_eq;
   logic [n_alu-1:0]       w_lt;
   alu_op_e                w_op;

   logic [n_alu*WIDTH-1:0] r_data;
   logic [n_alu-1:0]       r_carry;
   logic [n_alu-1:0]       r_gt;
   logic [n_alu-1:0]       r_eq;
   logic [n_alu-1:0]       r_lt;

   assign w_op = alu_op_e'(bus.select);

   generate
      for (genvar gi = 0; gi < n_alu; gi++) begin : g_lane
         alu_lane #(.WIDTH(WIDTH)) u_lane (
            .a     (bus.a[gi*WIDTH +: WIDTH]),
            .b     (bus.b[gi*WIDTH +: WIDTH]),
            .op    (w_op),
            .res   (w_res[gi*WIDTH +: WIDTH]),
            .carry (w_carry[gi]),
            .gt    (w_gt[gi]),
            .eq    (w_eq[gi]),
            .lt    (w_lt[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data  <= '0;
         r_carry <= '0;
         r_gt    <= '0;
         r_eq    <= '0;
         r_lt    <= '0;
      end else begin
         r_data  <= w_res;
         r_carry <= w_carry;
         r_gt    <= w_gt;
         r_eq    <= w_eq;
         r_lt    <= w_lt;
      end
   end

   assign bus.data_out  = r_data;
   assign bus.carry_out = r_carry;
   assign bus.a_greater = r_gt;
   assign bus.a_equal   = r_eq;
   assign bus.a_less    = r_lt;

endmodule

// File: tb/tb_alu_vectorial.sv
// Self-checking bench for alu_vectorial: directed spec vectors plus randomized back-to-back traffic.
module tb_alu_vectorial;
   import alu_pkg::*;

   localparam int W = 4;
   localparam int N = 4;

   logic clk;
   int   n_checks = 0;
   int   n_fail   = 0;

   alu_if #(.WIDTH(W), .n_alu(N)) bus (.clk(clk));

   alu_vectorial #(.WIDTH(W), .n_alu(N)) dut (
      .clk (clk),
      .rst (bus.rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   // Per-lane arithmetic straight from the opcode table, using plain integers.
   function automatic void ref_model(input logic [15:0] a, input logic [15:0] b, input int op,
                                     output logic [15:0] d, output logic [3:0] c,
                                     output logic [3:0] g, output logic [3:0] e, output logic [3:0] l);
      d = '0; c = '0; g = '0; e = '0; l = '0;
      for (int i = 0; i < N; i++) begin
         int x;
         int y;
         int r;
         int cy;
         x  = int'((a >> (4 * i)) & 16'hF);
         y  = int'((b >> (4 * i)) & 16'hF);
         cy = 0;
         case (op)
            0: begin r = x + y; cy = r / 16; r = r % 16; end
            1: begin r = (x - y + 16) % 16; cy = (x < y) ? 1 : 0; end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = 15 - x;
            6: begin r = (x * 2) % 16; cy = x / 8; end
            default: begin r = x / 2; cy = x % 2; end
         endcase
         d[4*i +: 4] = r[3:0];
         c[i] = cy[0];
         g[i] = (x > y);
         e[i] = (x == y);
         l[i] = (x < y);
      end
   endfunction

   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] sel);
      bus.a      = a;
      bus.b      = b;
      bus.select = sel;
      $display("txn a=%h b=%h select=%b", a, b, sel);
   endtask

   task automatic test_reset();
      bus.rst = 1'b0;
      drive(16'h0000, 16'h0000, 3'b000);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({bus.data_out, bus.carry_out, bus.a_greater, bus.a_equal, bus.a_less} !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state: got %h required 0",
                  {bus.data_out, bus.carry_out, bus.a_greater, bus.a_equal, bus.a_less});
      end
      @(negedge clk);
      bus.rst = 1'b1;
      drive(16'hF321, 16'h1111, 3'b000);
      @(posedge clk);
      #2;
      n_checks++;
      if (bus.data_out !== 16'h0432) begin
         n_fail++;
         $display("FAIL reset_preload: data_out got %h required 0432", bus.data_out);
      end
      bus.rst = 1'b0;
      #1;
      n_checks++;
      if (bus.data_out !== 16'h0 || bus.carry_out !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_async_data: data_out=%h carry=%b required 0", bus.data_out, bus.carry_out);
      end
      n_checks++;
      if (bus.a_greater !== 4'h0 || bus.a_equal !== 4'h0 || bus.a_less !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_async_flags: gt=%b eq=%b lt=%b required 0", bus.a_greater, bus.a_equal, bus.a_less);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.data_out !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_hold: data_out got %h required 0", bus.data_out);
      end
      @(negedge clk);
      bus.rst = 1'b1;
      drive(16'h0001, 16'h0001, 3'b000);
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.data_out !== 16'h0002 || bus.carry_out !== 4'b0000 || bus.a_equal !== 4'b1111) begin
         n_fail++;
         $display("FAIL reset_release_add: data=%h carry=%b eq=%b required 0002 0000 1111",
                  bus.data_out, bus.carry_out, bus.a_equal);
      end
   endtask

   task automatic test_add();
      drive(16'hF321, 16'h1111, 3'b000);
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.data_out !== 16'h0432 || bus.carry_out !== 4'b1000) begin
         n_fail++;
         $display("FAIL add_result: data=%h carry=%b required 0432 1000", bus.data_out, bus.carry_out);
      end
      n_checks++;
      if (bus.a_greater !== 4'b1110 || bus.a_equal !== 4'b0001 || bus.a_less !== 4'b0000) begin
         n_fail++;
         $display("FAIL add_flags: gt=%b eq=%b lt=%b required 1110 0001 0000",
                  bus.a_greater, bus.a_equal, bus.a_less);
      end
   endtask

   task automatic test_sub();
      drive(16'h0235, 16'h1134, 3'b001);
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.data_out !== 16'hF101 || bus.carry_out !== 4'b1000) begin
         n_fail++;
         $display("FAIL sub_result: data=%h carry=%b required F101 1000", bus.data_out, bus.carry_out);
      end
      // Lane 1 holds 3 vs 3, lanes 0 and 2 are greater, lane 3 borrows.
      n_checks++;
      if (bus.a_greater !== 4'b0101 || bus.a_equal !== 4'b0010 || bus.a_less !== 4'b1000) begin
         n_fail++;
         $display("FAIL sub_flags: gt=%b eq=%b lt=%b required 0101 0010 1000",
                  bus.a_greater, bus.a_equal, bus.a_less);
      end
   endtask

   task automatic test_logic();
      logic [15:0] exp_d [4] = '{16'h05F0, 16'hAFF0, 16'hAA00, 16'h5A0F};
      for (int k = 0; k < 4; k++) begin
         logic [2:0] sel;
         sel = 3'(k + 2);
         drive(16'hA5F0, 16'h0FF0, sel);
         @(posedge clk);
         #1;
         n_checks++;
         if (bus.data_out !== exp_d[k] || bus.carry_out !== 4'b0000) begin
            n_fail++;
            $display("FAIL logic_op%0d: data=%h carry=%b required %h 0000",
                     sel, bus.data_out, bus.carry_out, exp_d[k]);
         end
      end
   endtask

   task automatic test_shifts();
      drive(16'h8181, 16'h0000, 3'b110);
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.data_out !== 16'h0202 || bus.carry_out !== 4'b1010) begin
         n_fail++;
         $display("FAIL shl: data=%h carry=%b required 0202 1010", bus.data_out, bus.carry_out);
      end
      drive(16'h8181, 16'h0000, 3'b111);
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.data_out !== 16'h4040 || bus.carry_out !== 4'b0101) begin
         n_fail++;
         $display("FAIL shr: data=%h carry=%b required 4040 0101", bus.data_out, bus.carry_out);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ed;
      logic [3:0]  ec, eg, ee, el;
      logic [15:0] ra, rb;
      logic [2:0]  rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 3'($urandom_range(7));
      ref_model(ra, rb, int'(rs), ed, ec, eg, ee, el);
      drive(ra, rb, rs);
      for (int k = 0; k < 24; k++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (bus.data_out !== ed || bus.carry_out !== ec) begin
            n_fail++;
            $display("FAIL b2b_result[%0d]: data=%h carry=%b required %h %b",
                     k, bus.data_out, bus.carry_out, ed, ec);
         end
         n_checks++;
         if (bus.a_greater !== eg || bus.a_equal !== ee || bus.a_less !== el) begin
            n_fail++;
            $display("FAIL b2b_flags[%0d]: gt=%b eq=%b lt=%b required %b %b %b",
                     k, bus.a_greater, bus.a_equal, bus.a_less, eg, ee, el);
         end
         // Bias some cycles toward equal lanes so eq/borrow edges get exercised.
         ra = 16'($urandom);
         rb = (k % 4 == 3) ? (ra ^ (16'hF << (4 * (k % 4)))) : 16'($urandom);
         rs = 3'($urandom_range(7));
         ref_model(ra, rb, int'(rs), ed, ec, eg, ee, el);
         drive(ra, rb, rs);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_shifts();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
